spi_master_ctrl: RTL and testbench
==================================

# spi_master_ctrl

Synchronous SPI master that sits directly upstream of the SPI slave / single-port-RAM wrapper and drives its MOSI/SS_n pins from a simple valid/ready command interface. Each accepted command becomes one framed transaction: write-address, write-data, read-address or read-data. Read-data frames capture the 8-bit byte returned on MISO and present it on a one-cycle response strobe. Master and slave share one clock: one bit per clk cycle, no divided SCK.

## Interface
- RD_LAT, 2: cycles between the last MOSI bit and the first MISO bit sampled in a read-data frame (1..15)
- GAP, 1: cycles SS_n is held high between frames (>=1)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready
- cmd_type  in  2  00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
- cmd_data  in  8  address or write byte (ignored for rd-data)
- rsp_valid  out  1  one-cycle pulse, read byte available
- rsp_data  out  8  captured read byte, held until next rsp_valid
- busy  out  1  high whenever state != IDLE
- SS_n  out  1  slave select, active low
- MOSI  out  1  serial data to slave
- MISO  in  1  serial data from slave

## Operation
- States: IDLE, SEL, SEND, TURN, RECV, GAP.
- IDLE: SS_n=1, MOSI=0. On accept, latch cmd_type/cmd_data into shift register {cmd_type[1], cmd_type, cmd_data} (11 bits) -> SEL.
- SEL: SS_n driven low for 1 cycle, MOSI=0 -> SEND.
- SEND: 11 bits shifted MSB first, one per cycle: mode bit (=cmd_type[1]), cmd_type[1:0], cmd_data[7:0]. After bit 11: rd-data -> TURN, otherwise -> GAP.
- TURN: RD_LAT cycles, SS_n low, MOSI=0 -> RECV.
- RECV: 8 cycles, MISO sampled into rsp_data MSB first; rsp_valid pulses the cycle after the 8th sample -> GAP.
- GAP: SS_n=1 for GAP cycles -> IDLE (or SEL when auto-read pending, see Configuration).
- Bit counter 4 bits, wraps only by explicit reload; no frame exceeds 11 bits on MOSI or 8 on MISO.
- cmd_valid while busy is ignored (cmd_ready=0); no queueing.
- Reset mid-frame: immediate return to IDLE, SS_n=1 asynchronously; partial frame discarded, no rsp_valid.

## Timing
- Reset values: SS_n=1, MOSI=0, cmd_ready=0 during reset then 1 from the first clock edge in IDLE, busy=0, rsp_valid=0, rsp_data=8'h00.
- Outputs registered; SS_n falls the cycle after accept; first MOSI bit one cycle later.
- Write frame length: 1 + 11 + GAP cycles from accept to cmd_ready.
- Read-data frame: 1 + 11 + RD_LAT + 8 + GAP cycles; rsp_valid asserted in the first GAP cycle.
- Back-to-back accept possible the cycle cmd_ready returns.

## Configuration
- SPI_MASTER_AUTO_RD_EN defined: an accepted rd-addr command, after its GAP, automatically issues a rd-data frame (SEL entered directly, cmd_ready stays 0) and returns the byte via rsp_valid; cmd_type 11 is still accepted standalone.
- Undefined: rd-addr ends after GAP like a write; host must issue rd-data itself.

## Structure
- Shared package spi_pkg: cmd_type encodings (CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA), state enum, frame length constant (11), data width (8).
- Single module; no sub-module. Bench pairs it with the existing slave/RAM wrapper over MOSI/SS_n/MISO.

## Test plan
- wr-addr 8'hFF then wr-data 8'h55 -> MOSI streams 0,00,11111111 and 0,01,01010101; RAM[8'hFF]=8'h55.
- rd-addr 8'hFF then rd-data -> rsp_valid one pulse, rsp_data=8'h55, at cycle 1+11+RD_LAT+8 after accept.
- cmd_valid held high while busy with different cmd_data -> ignored; only first command framed.
- rst asserted at bit 6 of a wr-data frame -> SS_n=1 same cycle, RAM unchanged, cmd_ready=1 after release.
- SPI_MASTER_AUTO_RD_EN defined, preload RAM[8'h10]=8'hA3, single rd-addr 8'h10 -> two frames, rsp_data=8'hA3, cmd_ready low throughout.
- RD_LAT=1 and GAP=3 variant -> frame lengths match Timing formulas exactly.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared definitions for the single-clock SPI master that
//                drives the SPI slave / single-port-RAM wrapper.
//                Command encodings, controller state enum and frame
//                geometry (11-bit MOSI frame, 8-bit data byte).
//  Revision    : 1.0  initial release
// ============================================================================
package spi_pkg;

    // Command encodings carried in cmd_type and in frame bits [9:8]
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // Frame geometry: {mode, cmd_type[1:0], data[7:0]}
    localparam int FRAME_LEN = 11;
    localparam int DATA_W    = 8;
    localparam int CNT_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEL  = 3'd1,
        ST_SEND = 3'd2,
        ST_TURN = 3'd3,
        ST_RECV = 3'd4,
        ST_GAP  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_ctrl
//  Description : Single-clock SPI master. Each command accepted on the
//                valid/ready interface becomes one framed transaction on
//                SS_n/MOSI (one bit per clk). Read-data frames capture the
//                byte returned on MISO and return it with a one-cycle
//                rsp_valid strobe.
//  Parameters  : RD_LAT  cycles between last MOSI bit and first MISO sample
//                GAP     cycles SS_n stays high between frames (>=1)
//  Ports       : clk, rst (async, active-high)
//                cmd_valid/cmd_ready/cmd_type/cmd_data  command in
//                rsp_valid/rsp_data                     read byte out
//                busy                                   state != IDLE
//                SS_n/MOSI/MISO                         SPI pins
//  Macro       : SPI_MASTER_AUTO_RD_EN - a rd-addr command automatically
//                follows up with a rd-data frame after its gap.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int GAP    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_type,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
);

    // Down-counter reload values; each phase runs until the counter hits 0.
    localparam logic [CNT_W-1:0] c_send_load = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] c_turn_load = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] c_recv_load = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] c_gap_load  = CNT_W'(GAP - 1);

`ifdef SPI_MASTER_AUTO_RD_EN
    localparam logic c_auto_rd = 1'b1;
`else
    localparam logic c_auto_rd = 1'b0;
`endif

    state_t                r_state;
    logic [FRAME_LEN-1:0]  r_shift;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_W-1:0]     r_rx;
    logic                  r_rd_frame;   // current frame is a rd-data frame
    logic                  r_auto_pend;  // rd-data frame owed after this gap

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_rx        <= '0;
            r_rd_frame  <= 1'b0;
            r_auto_pend <= 1'b0;
            cmd_ready   <= 1'b0;
            busy        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            SS_n        <= 1'b1;
            MOSI        <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    SS_n      <= 1'b1;
                    MOSI      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        r_shift     <= {cmd_type[1], cmd_type, cmd_data};
                        r_rd_frame  <= (cmd_type == CMD_RD_DATA);
                        r_auto_pend <= c_auto_rd && (cmd_type == CMD_RD_ADDR);
                        r_state     <= ST_SEL;
                        SS_n        <= 1'b0;
                        cmd_ready   <= 1'b0;
                        busy        <= 1'b1;
                    end
                end

                ST_SEL: begin
                    // Present the MSB now so it is on MOSI for the first SEND cycle
                    MOSI    <= r_shift[FRAME_LEN-1];
                    r_shift <= {r_shift[FRAME_LEN-2:0], 1'b0};
                    r_cnt   <= c_send_load;
                    r_state <= ST_SEND;
                end

                ST_SEND: begin
                    if (r_cnt == '0) begin
                        MOSI <= 1'b0;
                        if (r_rd_frame) begin
                            r_cnt   <= c_turn_load;
                            r_state <= ST_TURN;
                        end else begin
                            SS_n    <= 1'b1;
                            r_cnt   <= c_gap_load;
                            r_state <= ST_GAP;
                        end
                    end else begin
                        MOSI    <= r_shift[FRAME_LEN-1];
                        r_shift <= {r_shift[FRAME_LEN-2:0], 1'b0};
                        r_cnt   <= r_cnt - 1'b1;
                    end
                end

                ST_TURN: begin
                    if (r_cnt == '0) begin
                        r_cnt   <= c_recv_load;
                        r_state <= ST_RECV;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                ST_RECV: begin
                    r_rx <= {r_rx[DATA_W-2:0], MISO};
                    if (r_cnt == '0) begin
                        // Last sample goes straight into the response register
                        rsp_data  <= {r_rx[DATA_W-2:0], MISO};
                        rsp_valid <= 1'b1;
                        SS_n      <= 1'b1;
                        r_cnt     <= c_gap_load;
                        r_state   <= ST_GAP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                ST_GAP: begin
                    if (r_cnt == '0) begin
                        if (r_auto_pend) begin
                            // Follow-up rd-data frame; host interface stays closed
                            r_shift     <= {1'b1, CMD_RD_DATA, {DATA_W{1'b0}}};
                            r_rd_frame  <= 1'b1;
                            r_auto_pend <= 1'b0;
                            SS_n        <= 1'b0;
                            r_state     <= ST_SEL;
                        end else begin
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                            r_state   <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                default: begin
                    SS_n      <= 1'b1;
                    MOSI      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master_ctrl
//  Description : Self-checking bench for spi_master_ctrl. A behavioural
//                slave/RAM model sits on MOSI/SS_n/MISO; expected frames and
//                read bytes are queued as commands are issued and compared
//                as the DUT produces them. A second instance with RD_LAT=1,
//                GAP=3 checks the frame-length formulas.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_master_ctrl;
    import spi_pkg::*;

    localparam int RD_LAT = 2;
    localparam int GAP    = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;

    // Main DUT
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_type  = 2'b00;
    logic [7:0] cmd_data  = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       ss_n;
    logic       mosi;
    logic       miso = 1'b0;

    // Variant DUT
    logic       cmd_valid2 = 1'b0;
    logic       cmd_ready2;
    logic [1:0] cmd_type2  = 2'b00;
    logic [7:0] cmd_data2  = 8'h00;
    logic       rsp_valid2;
    logic [7:0] rsp_data2;
    logic       busy2;
    logic       ss_n2;
    logic       mosi2;
    logic       miso2 = 1'b1;

    int n_pass  = 0;
    int n_total = 0;

    logic [10:0] exp_frames[$];
    logic [7:0]  exp_rsp[$];

    // Slave / RAM model state
    logic [7:0]  mem [256];
    logic [7:0]  s_addr  = 8'h00;
    logic [10:0] s_frame = '0;
    logic [7:0]  s_rbyte = 8'h00;
    logic        s_rd    = 1'b0;
    int          s_cnt   = 0;
    int          frames_seen = 0;
    logic [10:0] frame_exp_v;

    int          rsp_count = 0;
    int          last_rsp_cyc = 0;
    logic [7:0]  rsp_exp_v;

    spi_master_ctrl #(.RD_LAT(RD_LAT), .GAP(GAP)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .SS_n(ss_n), .MOSI(mosi), .MISO(miso)
    );

    spi_master_ctrl #(.RD_LAT(1), .GAP(3)) dut2 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .cmd_type(cmd_type2), .cmd_data(cmd_data2),
        .rsp_valid(rsp_valid2), .rsp_data(rsp_data2),
        .busy(busy2), .SS_n(ss_n2), .MOSI(mosi2), .MISO(miso2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    end

    // Slave model: s_cnt counts cycles since SS_n fell (0 = select cycle)
    always @(negedge clk) begin
        if (ss_n !== 1'b0) begin
            s_cnt = 0;
            s_rd  = 1'b0;
            miso  = 1'b0;
        end else begin
            if (s_cnt >= 1 && s_cnt <= 11) s_frame = {s_frame[9:0], mosi};
            if (s_cnt == 11) begin
                frames_seen++;
                n_total++;
                if (exp_frames.size() == 0) begin
                    $display("FAIL frame: unexpected frame %b, none queued", s_frame);
                end else begin
                    frame_exp_v = exp_frames.pop_front();
                    if (s_frame !== frame_exp_v)
                        $display("FAIL frame: got %b expected %b", s_frame, frame_exp_v);
                    else
                        n_pass++;
                end
                case (s_frame[9:8])
                    CMD_WR_ADDR, CMD_RD_ADDR: s_addr = s_frame[7:0];
                    CMD_WR_DATA:              mem[s_addr] = s_frame[7:0];
                    default: begin
                        s_rbyte = mem[s_addr];
                        s_rd    = 1'b1;
                    end
                endcase
            end
            if (s_rd && s_cnt >= 12 + RD_LAT && s_cnt <= 19 + RD_LAT)
                miso = s_rbyte[19 + RD_LAT - s_cnt];
            else
                miso = 1'b0;
            s_cnt++;
        end
    end

    // Response scoreboard
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            rsp_count++;
            last_rsp_cyc = cyc;
            n_total++;
            if (exp_rsp.size() == 0) begin
                $display("FAIL rsp: unexpected rsp_data %h, none queued", rsp_data);
            end else begin
                rsp_exp_v = exp_rsp.pop_front();
                if (rsp_data !== rsp_exp_v)
                    $display("FAIL rsp: got %h expected %h", rsp_data, rsp_exp_v);
                else
                    n_pass++;
            end
        end
    end

    // Issue one command on the main DUT; acc = cyc at the negedge after accept
    task automatic drive_cmd(input logic [1:0] t, input logic [7:0] d, output int acc);
        for (int g = 0; g < 100 && cmd_ready !== 1'b1; g++) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_data  = d;
        exp_frames.push_back({t[1], t, d});
        @(negedge clk);
        cmd_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_ready(input int acc, output int delta);
        for (int g = 0; g < 200 && cmd_ready !== 1'b1; g++) @(negedge clk);
        delta = cyc - acc;
    endtask

    task automatic rd_addr(input logic [7:0] a, output int delta);
        int acc;
        drive_cmd(CMD_RD_ADDR, a, acc);
`ifdef SPI_MASTER_AUTO_RD_EN
        exp_frames.push_back({1'b1, CMD_RD_DATA, 8'h00});
`endif
        wait_ready(acc, delta);
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (ss_n !== 1'b1 || mosi !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b0 ||
            rsp_valid !== 1'b0 || rsp_data !== 8'h00)
            $display("FAIL reset_values: ss_n=%b mosi=%b rdy=%b busy=%b rv=%b rd=%h required 1 0 0 0 0 00",
                     ss_n, mosi, cmd_ready, busy, rsp_valid, rsp_data);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_release: cmd_ready=%b busy=%b required 1 0", cmd_ready, busy);
        else n_pass++;
    endtask

    task automatic test_write();
        int a, d;
        drive_cmd(CMD_WR_ADDR, 8'hFF, a);
        n_total++;
        if (ss_n !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0 || mosi !== 1'b0)
            $display("FAIL sel_cycle: ss_n=%b busy=%b rdy=%b mosi=%b required 0 1 0 0",
                     ss_n, busy, cmd_ready, mosi);
        else n_pass++;
        wait_ready(a, d);
        n_total++;
        if (d !== 1 + 11 + GAP) $display("FAIL wr_len: got %0d required %0d", d, 1 + 11 + GAP);
        else n_pass++;
        drive_cmd(CMD_WR_DATA, 8'h55, a);
        wait_ready(a, d);
        n_total++;
        if (mem[8'hFF] !== 8'h55) $display("FAIL ram_write: got %h required 55", mem[8'hFF]);
        else n_pass++;
    endtask

    task automatic test_read();
        int a, d, rc0;
`ifdef SPI_MASTER_AUTO_RD_EN
        exp_rsp.push_back(8'h55);
`endif
        rd_addr(8'hFF, d);
        n_total++;
`ifdef SPI_MASTER_AUTO_RD_EN
        if (d !== (12 + GAP) + (20 + RD_LAT + GAP))
            $display("FAIL rdaddr_len: got %0d required %0d", d, (12 + GAP) + (20 + RD_LAT + GAP));
`else
        if (d !== 1 + 11 + GAP)
            $display("FAIL rdaddr_len: got %0d required %0d", d, 1 + 11 + GAP);
`endif
        else n_pass++;
        rc0 = rsp_count;
        exp_rsp.push_back(8'h55);
        drive_cmd(CMD_RD_DATA, 8'h00, a);
        wait_ready(a, d);
        n_total++;
        if (rsp_count !== rc0 + 1) $display("FAIL rsp_pulses: got %0d required 1", rsp_count - rc0);
        else n_pass++;
        n_total++;
        if (last_rsp_cyc - a !== 1 + 11 + RD_LAT + 8)
            $display("FAIL rsp_time: got %0d required %0d", last_rsp_cyc - a, 1 + 11 + RD_LAT + 8);
        else n_pass++;
        n_total++;
        if (d !== 1 + 11 + RD_LAT + 8 + GAP)
            $display("FAIL rd_len: got %0d required %0d", d, 1 + 11 + RD_LAT + 8 + GAP);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (rsp_data !== 8'h55 || rsp_valid !== 1'b0)
            $display("FAIL rsp_hold: rsp_data=%h rsp_valid=%b required 55 0", rsp_data, rsp_valid);
        else n_pass++;
    endtask

    task automatic test_busy_ignore();
        int a, d, f0;
        f0 = frames_seen;
        for (int g = 0; g < 100 && cmd_ready !== 1'b1; g++) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_type  = CMD_WR_ADDR;
        cmd_data  = 8'h12;
        exp_frames.push_back({1'b0, CMD_WR_ADDR, 8'h12});
        @(negedge clk);
        a = cyc;
        cmd_type = CMD_WR_DATA;
        cmd_data = 8'h34;
        repeat (8) @(negedge clk);
        n_total++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL busy_hold: cmd_ready=%b busy=%b required 0 1", cmd_ready, busy);
        else n_pass++;
        cmd_valid = 1'b0;
        wait_ready(a, d);
        n_total++;
        if (frames_seen !== f0 + 1 || s_addr !== 8'h12)
            $display("FAIL busy_ignore: frames=%0d addr=%h required 1 12", frames_seen - f0, s_addr);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int a, d, rc0;
        drive_cmd(CMD_WR_ADDR, 8'h20, a);
        wait_ready(a, d);
        drive_cmd(CMD_WR_DATA, 8'h77, a);
        wait_ready(a, d);
        rc0 = rsp_count;
        drive_cmd(CMD_WR_DATA, 8'h99, a);
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (ss_n !== 1'b1 || busy !== 1'b0 || mosi !== 1'b0)
            $display("FAIL rst_async: ss_n=%b busy=%b mosi=%b required 1 0 0", ss_n, busy, mosi);
        else n_pass++;
        exp_frames.delete(exp_frames.size() - 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (cmd_ready !== 1'b1 || mem[8'h20] !== 8'h77 || rsp_count !== rc0)
            $display("FAIL rst_mid: rdy=%b ram=%h rsp=%0d required 1 77 0",
                     cmd_ready, mem[8'h20], rsp_count - rc0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int a1, a2, d;
        drive_cmd(CMD_WR_ADDR, 8'h30, a1);
        drive_cmd(CMD_WR_DATA, 8'hC3, a2);
        n_total++;
        if (a2 - a1 !== 1 + 11 + GAP + 1)
            $display("FAIL b2b_accept: got %0d required %0d", a2 - a1, 1 + 11 + GAP + 1);
        else n_pass++;
        wait_ready(a2, d);
        n_total++;
        if (mem[8'h30] !== 8'hC3) $display("FAIL b2b_ram: got %h required c3", mem[8'h30]);
        else n_pass++;
`ifdef SPI_MASTER_AUTO_RD_EN
        exp_rsp.push_back(8'hC3);
`endif
        rd_addr(8'h30, d);
        exp_rsp.push_back(8'hC3);
        drive_cmd(CMD_RD_DATA, 8'h00, a1);
        wait_ready(a1, d);
    endtask

`ifdef SPI_MASTER_AUTO_RD_EN
    task automatic test_auto_read();
        int a, rc0;
        logic rdy_seen;
        mem[8'h10] = 8'hA3;
        rc0 = rsp_count;
        rdy_seen = 1'b0;
        exp_rsp.push_back(8'hA3);
        drive_cmd(CMD_RD_ADDR, 8'h10, a);
        exp_frames.push_back({1'b1, CMD_RD_DATA, 8'h00});
        for (int g = 0; g < 100 && rsp_count == rc0; g++) begin
            if (cmd_ready !== 1'b0) rdy_seen = 1'b1;
            @(negedge clk);
        end
        n_total++;
        if (rdy_seen !== 1'b0) $display("FAIL auto_ready: cmd_ready rose before response");
        else n_pass++;
        n_total++;
        if (last_rsp_cyc - a !== (12 + GAP) + (20 + RD_LAT) || rsp_count !== rc0 + 1)
            $display("FAIL auto_rsp: time=%0d count=%0d required %0d 1",
                     last_rsp_cyc - a, rsp_count - rc0, (12 + GAP) + (20 + RD_LAT));
        else n_pass++;
        for (int g = 0; g < 100 && cmd_ready !== 1'b1; g++) @(negedge clk);
    endtask
`endif

    task automatic test_timing_variant();
        int a, rc, rsp_at;
        logic [10:0] bits;
        logic [7:0] rd;
        for (int g = 0; g < 100 && cmd_ready2 !== 1'b1; g++) @(negedge clk);
        cmd_valid2 = 1'b1;
        cmd_type2  = CMD_WR_ADDR;
        cmd_data2  = 8'h5A;
        @(negedge clk);
        cmd_valid2 = 1'b0;
        a = cyc;
        n_total++;
        if (ss_n2 !== 1'b0) $display("FAIL v_sel: ss_n=%b required 0", ss_n2);
        else n_pass++;
        bits = '0;
        for (int g = 0; g < 100 && cmd_ready2 !== 1'b1; g++) begin
            if (cyc - a >= 1 && cyc - a <= 11) bits = {bits[9:0], mosi2};
            @(negedge clk);
        end
        n_total++;
        if (bits !== {1'b0, CMD_WR_ADDR, 8'h5A})
            $display("FAIL v_frame: got %b required %b", bits, {1'b0, CMD_WR_ADDR, 8'h5A});
        else n_pass++;
        n_total++;
        if (cyc - a !== 15) $display("FAIL v_wr_len: got %0d required 15", cyc - a);
        else n_pass++;
        cmd_valid2 = 1'b1;
        cmd_type2  = CMD_RD_DATA;
        cmd_data2  = 8'h00;
        @(negedge clk);
        cmd_valid2 = 1'b0;
        a = cyc;
        rc = 0;
        rsp_at = -1;
        rd = 8'h00;
        for (int g = 0; g < 100 && cmd_ready2 !== 1'b1; g++) begin
            if (rsp_valid2 === 1'b1) begin
                rc++;
                rsp_at = cyc - a;
                rd = rsp_data2;
            end
            @(negedge clk);
        end
        n_total++;
        if (rc !== 1 || rsp_at !== 21 || rd !== 8'hFF)
            $display("FAIL v_rsp: pulses=%0d time=%0d data=%h required 1 21 ff", rc, rsp_at, rd);
        else n_pass++;
        n_total++;
        if (cyc - a !== 24) $display("FAIL v_rd_len: got %0d required 24", cyc - a);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
`ifdef SPI_MASTER_AUTO_RD_EN
        test_auto_read();
`endif
        test_timing_variant();
        repeat (4) @(negedge clk);
        n_total++;
        if (exp_frames.size() != 0 || exp_rsp.size() != 0)
            $display("FAIL drain: frames left=%0d rsp left=%0d required 0 0",
                     exp_frames.size(), exp_rsp.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
